vc_input_buffer: RTL and testbench

Input-port buffering stage of the virtual channel router. It accepts one flit per cycle from the upstream link, steers it into one of NUM_VC per-VC FIFOs, and tracks packet framing per VC. It presents each VC's head flit to the downstream allocation/switch stage and returns one credit upstream for every flit popped. It sits between the link receiver and the VC/switch allocators.

---
 rtl/vc_input_buffer.sv | 142 ++++++++++++++
 tb/tb_vc_input_buffer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_input_buffer.sv
// Input VC buffer: steers incoming flits into per-VC FIFOs, checks packet framing, returns credits on pop.
// Latency: push visible on out_* one edge later; credit registered one edge after pop. No backpressure: credit flow, drops set sticky err.

`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 32
`endif

// Generic circular FIFO; caller guarantees push only with room (or with a same-cycle pop) and pop only when non-empty.
// Latency: write visible at front one edge later. No internal flow control.
module vc_ib_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           front_dat,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  // DEPTH is a power of two, so the natural pointer overflow is the DEPTH-1 -> 0 wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  assign front_dat = mem[rd_ptr];
endmodule

// Per-port input buffer of the VC router: one flit in and one flit popped per cycle.
// Latency: 1 cycle push-to-front, credit 1 cycle after pop. Illegal framing or full-VC pushes are dropped and flag err.
module vc_input_buffer #(
  parameter int NUM_VC = 4,
  parameter int DEPTH  = 8,
  parameter int DATA_W = `FLIT_DATA_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  input  logic [$clog2(NUM_VC)-1:0]             in_vc,
  input  logic                                  in_head,
  input  logic                                  in_tail,
  input  logic [DATA_W-1:0]                     in_data,
  output logic [NUM_VC-1:0]                     out_valid,
  output logic [NUM_VC-1:0]                     out_head,
  output logic [NUM_VC-1:0]                     out_tail,
  output logic [NUM_VC*DATA_W-1:0]              out_data,
  input  logic                                  pop_valid,
  input  logic [$clog2(NUM_VC)-1:0]             pop_vc,
  output logic                                  credit_valid,
  output logic [$clog2(NUM_VC)-1:0]             credit_vc,
  output logic [NUM_VC*$clog2(DEPTH+1)-1:0]     vc_count,
  output logic                                  err
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = DATA_W + 2;

  typedef enum logic {IDLE, ACTIVE} frame_t;

  frame_t            frame [NUM_VC];
  logic [CW-1:0]     cnt   [NUM_VC];
  logic [EW-1:0]     front [NUM_VC];
  logic [NUM_VC-1:0] push_v;
  logic [NUM_VC-1:0] pop_v;
  logic              pop_ok;
  logic              frame_ok;
  logic              room_ok;
  logic              push_ok;
  logic              drop;

  // A full VC still accepts a push when the same VC is popped this cycle.
  always_comb begin
    pop_ok   = pop_valid && (cnt[pop_vc] != '0);
    frame_ok = (frame[in_vc] == ACTIVE) ? !in_head : in_head;
    room_ok  = (cnt[in_vc] != CW'(DEPTH)) || (pop_ok && (pop_vc == in_vc));
    push_ok  = in_valid && frame_ok && room_ok;
    drop     = in_valid && !(frame_ok && room_ok);
    push_v   = '0;
    pop_v    = '0;
    push_v[in_vc]  = push_ok;
    pop_v[pop_vc]  = pop_ok;
  end

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    vc_ib_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_v[v]),
      .push_dat  ({in_head, in_tail, in_data}),
      .pop       (pop_v[v]),
      .front_dat (front[v]),
      .count     (cnt[v])
    );

    // Gate by occupancy so stale storage never leaks out, including during reset.
    assign out_valid[v]                  = (cnt[v] != '0);
    assign out_head[v]                   = out_valid[v] & front[v][EW-1];
    assign out_tail[v]                   = out_valid[v] & front[v][EW-2];
    assign out_data[v*DATA_W +: DATA_W]  = out_valid[v] ? front[v][DATA_W-1:0] : '0;
    assign vc_count[v*CW +: CW]          = cnt[v];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < NUM_VC; v++) frame[v] <= IDLE;
      credit_valid <= 1'b0;
      credit_vc    <= '0;
      err          <= 1'b0;
    end else begin
      if (push_ok) frame[in_vc] <= in_tail ? IDLE : ACTIVE;
      credit_valid <= pop_ok;
      if (pop_ok) credit_vc <= pop_vc;
      if (drop)   err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_vc_input_buffer.sv
// Directed bench for vc_input_buffer: 4 VCs, depth 8, 8-bit payload.
module tb_vc_input_buffer;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [1:0]  in_vc;
  logic        in_head;
  logic        in_tail;
  logic [7:0]  in_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_head;
  logic [3:0]  out_tail;
  logic [31:0] out_data;
  logic        pop_valid;
  logic [1:0]  pop_vc;
  logic        credit_valid;
  logic [1:0]  credit_vc;
  logic [15:0] vc_count;
  logic        err;

  int checks = 0;
  int errors = 0;

  vc_input_buffer #(.NUM_VC(4), .DEPTH(8), .DATA_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_vc        (in_vc),
    .in_head      (in_head),
    .in_tail      (in_tail),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_head     (out_head),
    .out_tail     (out_tail),
    .out_data     (out_data),
    .pop_valid    (pop_valid),
    .pop_vc       (pop_vc),
    .credit_valid (credit_valid),
    .credit_vc    (credit_vc),
    .vc_count     (vc_count),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] vc, input logic h, input logic t, input logic [7:0] d);
    in_valid = 1'b1;
    in_vc    = vc;
    in_head  = h;
    in_tail  = t;
    in_data  = d;
  endtask

  task automatic no_push;
    in_valid = 1'b0;
    in_head  = 1'b0;
    in_tail  = 1'b0;
    in_data  = '0;
  endtask

  task automatic pop(input logic [1:0] vc);
    pop_valid = 1'b1;
    pop_vc    = vc;
  endtask

  task automatic no_pop;
    pop_valid = 1'b0;
    pop_vc    = '0;
  endtask

  function automatic logic [7:0] dat(input int v);
    return out_data[v*8 +: 8];
  endfunction

  function automatic logic [3:0] cnt(input int v);
    return vc_count[v*4 +: 4];
  endfunction

  initial begin
    int popn;
    int n;
    reset = 1'b0;
    in_vc = '0;
    no_push();
    no_pop();
    repeat (2) tick();
    chk("rst_out_valid", out_valid, 4'h0);
    chk("rst_vc_count", vc_count, 16'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_credit", {credit_valid, credit_vc}, 3'b000);
    chk("rst_err", err, 1'b0);
    reset = 1'b1;
    tick();

    // Single-flit packet on VC2.
    push(2'd2, 1'b1, 1'b1, 8'hA5);
    tick();
    no_push();
    chk("single_valid", out_valid, 4'b0100);
    chk("single_data", dat(2), 8'hA5);
    chk("single_count", cnt(2), 4'd1);
    chk("single_ht", {out_head[2], out_tail[2]}, 2'b11);
    pop(2'd2);
    tick();
    no_pop();
    chk("single_credit", {credit_valid, credit_vc}, 3'b110);
    chk("single_empty", out_valid, 4'b0000);
    tick();
    chk("single_credit_once", credit_valid, 1'b0);

    // Eight-flit packet through VC0.
    for (int i = 0; i < 8; i++) begin
      push(2'd0, i == 0, i == 7, 8'(i));
      tick();
    end
    no_push();
    chk("fill0_count", cnt(0), 4'd8);
    for (int i = 0; i < 8; i++) begin
      chk("fill0_order", dat(0), 8'(i));
      pop(2'd0);
      tick();
      chk("fill0_credit", {credit_valid, credit_vc}, 3'b100);
    end
    no_pop();
    chk("fill0_drained", out_valid, 4'h0);
    chk("fill0_err", err, 1'b0);

    // Overflow on VC1, then push+pop while full.
    for (int i = 0; i < 8; i++) begin
      push(2'd1, i == 0, 1'b0, 8'(8'h10 + i));
      tick();
    end
    chk("ovf_full", cnt(1), 4'd8);
    chk("ovf_err_before", err, 1'b0);
    push(2'd1, 1'b0, 1'b0, 8'h99);
    tick();
    chk("ovf_drop_count", cnt(1), 4'd8);
    chk("ovf_err", err, 1'b1);
    chk("ovf_front", dat(1), 8'h10);
    push(2'd1, 1'b0, 1'b1, 8'h88);
    pop(2'd1);
    tick();
    no_push();
    chk("ovf_pp_count", cnt(1), 4'd8);
    chk("ovf_pp_credit", {credit_valid, credit_vc}, 3'b101);
    for (int i = 0; i < 8; i++) begin
      chk("ovf_order", dat(1), (i < 7) ? 8'(8'h11 + i) : 8'h88);
      if (i == 7) chk("ovf_last_tail", out_tail[1], 1'b1);
      pop(2'd1);
      tick();
    end
    no_pop();
    chk("ovf_drained", cnt(1), 4'd0);

    // Reset pulse clears the sticky error.
    reset = 1'b0;
    #1;
    chk("pulse_err_clear", err, 1'b0);
    tick();
    reset = 1'b1;
    tick();

    // Framing: body to idle VC3, head to active VC0.
    push(2'd3, 1'b0, 1'b0, 8'h33);
    tick();
    chk("frm_body_idle_cnt", cnt(3), 4'd0);
    chk("frm_body_idle_vld", out_valid[3], 1'b0);
    chk("frm_body_idle_err", err, 1'b1);
    push(2'd0, 1'b1, 1'b0, 8'h30);
    tick();
    push(2'd0, 1'b1, 1'b0, 8'h31);
    tick();
    chk("frm_head_active_cnt", cnt(0), 4'd1);
    push(2'd0, 1'b0, 1'b1, 8'h32);
    tick();
    no_push();
    chk("frm_tail_accepted", cnt(0), 4'd2);
    chk("frm_first", dat(0), 8'h30);
    pop(2'd0);
    tick();
    chk("frm_second", dat(0), 8'h32);
    chk("frm_second_tail", out_tail[0], 1'b1);
    tick();
    no_pop();
    chk("frm_drained", cnt(0), 4'd0);

    // Interleaved VC0/VC1 traffic with VC1 popped every cycle; pointers wrap.
    popn = 0;
    n = 0;
    pop(2'd1);
    for (int c = 0; c < 20; c++) begin
      if ((c % 2 == 0) && (c < 12))
        push(2'd0, c == 0, c == 10, 8'(8'h40 + c / 2));
      else begin
        push(2'd1, n == 0, n == 13, 8'(8'h50 + n));
        n++;
      end
      if (out_valid[1]) begin
        chk("ilv_vc1_order", dat(1), 8'(8'h50 + popn));
        popn++;
      end
      tick();
    end
    no_push();
    for (int d = 0; d < 4; d++) begin
      if (out_valid[1]) begin
        chk("ilv_vc1_order", dat(1), 8'(8'h50 + popn));
        popn++;
      end
      tick();
    end
    no_pop();
    chk("ilv_vc1_total", popn, 14);
    chk("ilv_vc0_count", cnt(0), 4'd6);
    chk("ilv_vc1_count", cnt(1), 4'd0);
    chk("ilv_err_sticky", err, 1'b1);
    for (int k = 0; k < 6; k++) begin
      chk("ilv_vc0_order", dat(0), 8'(8'h40 + k));
      pop(2'd0);
      tick();
    end
    no_pop();
    chk("ilv_vc0_drained", out_valid, 4'h0);

    // Asynchronous reset mid-packet.
    push(2'd2, 1'b1, 1'b0, 8'h60);
    tick();
    push(2'd3, 1'b1, 1'b0, 8'h70);
    tick();
    push(2'd2, 1'b0, 1'b0, 8'h62);
    pop(2'd2);
    tick();
    no_push();
    no_pop();
    chk("arst_pre_valid", out_valid, 4'b1100);
    chk("arst_pre_credit", credit_valid, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 4'h0);
    chk("arst_out_data", out_data, 32'h0);
    chk("arst_out_ht", {out_head, out_tail}, 8'h00);
    chk("arst_vc_count", vc_count, 16'h0);
    chk("arst_credit", {credit_valid, credit_vc}, 3'b000);
    chk("arst_err", err, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    push(2'd2, 1'b0, 1'b0, 8'h63);
    tick();
    chk("arst_body_rejected", cnt(2), 4'd0);
    chk("arst_body_err", err, 1'b1);
    push(2'd2, 1'b1, 1'b0, 8'h64);
    tick();
    no_push();
    chk("arst_head_accepted", cnt(2), 4'd1);
    chk("arst_head_data", dat(2), 8'h64);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
